// File: rtl/cable_pkg.sv
// Shared types and constants for the cable tester sequencer.
package cable_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    SAMPLE,
    DONE
  } cable_state_t;

  localparam int CABLE_NW_DEF     = 8;
  localparam int CABLE_SETTLE_CYC = 8;

endpackage

// File: rtl/cable_rcv_sync.sv
// Two-flop synchronizer for the far-end receive lines, reset to all zeros.
module cable_rcv_sync
  import cable_pkg::*;
#(
  parameter int NW = CABLE_NW_DEF
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [NW-1:0] d_i,
  output logic [NW-1:0] q_o
);

  logic [NW-1:0] meta_q;
  logic [NW-1:0] sync_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/cable_test_ctrl.sv
// Cable tester sequencer: drives each wire in turn, waits on the settle timer, classifies open/short.
// Define CABLE_RCV_SYNC_EN to pass the receive lines through a 2-flop synchronizer before sampling.
module cable_test_ctrl
  import cable_pkg::*;
#(
  parameter int NW = CABLE_NW_DEF,
  parameter int IW = $clog2(NW)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [NW-1:0] drv_o,
  input  logic [NW-1:0] rcv_i,
  output logic          en_timer_o,
  input  logic          ready_i,
  output logic [NW-1:0] open_map_o,
  output logic [NW-1:0] short_map_o,
  output logic          pass_o
);

  cable_state_t  state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NW-1:0] drv_q, drv_d;
  logic          en_timer_q, en_timer_d;
  logic [NW-1:0] open_q, open_d;
  logic [NW-1:0] short_q, short_d;
  logic          pass_q, pass_d;
  logic [NW-1:0] rcv_s;
  logic [NW-1:0] expect_s;

`ifdef CABLE_RCV_SYNC_EN
  cable_rcv_sync #(
    .NW(NW)
  ) u_rcv_sync (
    .clk   (clk),
    .resetn(resetn),
    .d_i   (rcv_i),
    .q_o   (rcv_s)
  );
`else
  assign rcv_s = rcv_i;
`endif

  assign expect_s = NW'(1) << idx_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      drv_q      <= '0;
      en_timer_q <= 1'b0;
      open_q     <= '0;
      short_q    <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      drv_q      <= drv_d;
      en_timer_q <= en_timer_d;
      open_q     <= open_d;
      short_q    <= short_d;
      pass_q     <= pass_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    drv_d      = drv_q;
    en_timer_d = en_timer_q;
    open_d     = open_q;
    short_d    = short_q;
    pass_d     = pass_q;
    unique case (state_q)
      IDLE: begin
        drv_d      = '0;
        en_timer_d = 1'b0;
        if (start_i) begin
          open_d  = '0;
          short_d = '0;
          pass_d  = 1'b0;
          idx_d   = '0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        drv_d      = expect_s;
        en_timer_d = 1'b1;
        state_d    = SETTLE;
      end
      // Dropping the enable on the ready edge lets the timer wrap to 0 for the next wire.
      SETTLE: begin
        if (ready_i) begin
          en_timer_d = 1'b0;
          state_d    = SAMPLE;
        end
      end
      SAMPLE: begin
        open_d[idx_q]  = ~rcv_s[idx_q];
        short_d[idx_q] = |(rcv_s & ~expect_s);
        if (idx_q == IW'(NW - 1)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = DRIVE;
        end
      end
      DONE: begin
        drv_d   = '0;
        pass_d  = (open_q == '0) && (short_q == '0);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign drv_o       = drv_q;
  assign en_timer_o  = en_timer_q;
  assign open_map_o  = open_q;
  assign short_map_o = short_q;
  assign pass_o      = pass_q;

endmodule

// File: tb/tb_cable_test_ctrl.sv
// Directed bench for cable_test_ctrl with NW=4, an 8-state behavioural settle timer and wire-fault models.
module tb_cable_test_ctrl;

  localparam int NW = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic [NW-1:0] drv;
  logic [NW-1:0] rcv;
  logic          enTimer;
  logic          ready;
  logic [NW-1:0] openMap;
  logic [NW-1:0] shortMap;
  logic          pass;

  logic [2:0]    timerCnt;
  logic          readyForce = 1'b0;
  int            mode = 0;

  int            testsRun = 0;
  int            failCount = 0;

  int            cycToDone;
  int            busyLowSeen;
  logic [NW-1:0] drvSeq[$];
  logic [NW-1:0] lastDrv;
  logic          en0, en1, en8, en9;
  logic          passAtStart;
  logic [NW-1:0] openAtStart;
  logic [NW-1:0] shortAtStart;

  cable_test_ctrl #(
    .NW(NW),
    .IW(IW)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start_i    (start),
    .busy_o     (busy),
    .done_o     (done),
    .drv_o      (drv),
    .rcv_i      (rcv),
    .en_timer_o (enTimer),
    .ready_i    (ready),
    .open_map_o (openMap),
    .short_map_o(shortMap),
    .pass_o     (pass)
  );

  always #5 clk = ~clk;

  // Settle timer model: counts while enabled, ready on its eighth enabled cycle, wraps to 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) timerCnt <= 3'd0;
    else if (enTimer) timerCnt <= timerCnt + 3'd1;
  end

  assign ready = (enTimer && (timerCnt == 3'd7)) || readyForce;

  // Mode 0 loopback, 1 wire 2 open, 2 wires 1/3 shorted, 3 wire 0 open.
  always_comb begin
    rcv = drv;
    case (mode)
      1: rcv = drv & 4'b1011;
      2: begin
        rcv[1] = drv[1] | drv[3];
        rcv[3] = drv[1] | drv[3];
      end
      3: rcv = drv & 4'b1110;
      default: ;
    endcase
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Pulses start, then runs until done (bounded), recording drive sequence and timer enable.
  task automatic applyStimulus(input int extraA, input int extraB, input int spurAt);
    drvSeq.delete();
    busyLowSeen = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    cycToDone    = 0;
    lastDrv      = drv;
    en0          = enTimer;
    passAtStart  = pass;
    openAtStart  = openMap;
    shortAtStart = shortMap;
    en1 = 1'bx; en8 = 1'bx; en9 = 1'bx;
    while (!done && cycToDone < 200) begin
      start      = (cycToDone == extraA) || (cycToDone == extraB);
      readyForce = (cycToDone == spurAt);
      tick;
      cycToDone++;
      start      = 1'b0;
      readyForce = 1'b0;
      if (!busy) busyLowSeen++;
      if (drv != lastDrv) begin
        drvSeq.push_back(drv);
        lastDrv = drv;
      end
      if (cycToDone == 1) en1 = enTimer;
      if (cycToDone == 8) en8 = enTimer;
      if (cycToDone == 9) en9 = enTimer;
    end
    checkOutput("doneSeen", done, 1);
  endtask

  initial begin
    // Reset state
    tick;
    tick;
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstDrv", drv, 0);
    checkOutput("rstEn", enTimer, 0);
    checkOutput("rstOpen", openMap, 0);
    checkOutput("rstShort", shortMap, 0);
    checkOutput("rstPass", pass, 0);
    resetn = 1'b1;
    tick;

    // Loopback
    mode = 0;
    applyStimulus(-1, -1, -1);
    checkOutput("lbCycles", cycToDone, 40);
    checkOutput("lbBusyLow", busyLowSeen, 0);
    checkOutput("lbDrvCount", drvSeq.size(), 4);
    for (int i = 0; i < 4; i++) checkOutput("lbDrvSeq", drvSeq[i], 32'(1) << i);
    checkOutput("lbEnDrive", en0, 0);
    checkOutput("lbEnSettle1", en1, 1);
    checkOutput("lbEnSettle8", en8, 1);
    checkOutput("lbEnSample", en9, 0);
    checkOutput("lbOpen", openMap, 0);
    checkOutput("lbShort", shortMap, 0);
    tick;
    checkOutput("lbDrvEnd", drv, 0);
    checkOutput("lbDoneOnce", done, 0);
    checkOutput("lbBusyEnd", busy, 0);
    checkOutput("lbPass", pass, 1);

    // Open wire 2, started one cycle after done
    mode = 1;
    applyStimulus(-1, -1, -1);
    checkOutput("opClrPass", passAtStart, 0);
    checkOutput("opCycles", cycToDone, 40);
    checkOutput("opOpen", openMap, 4'b0100);
    checkOutput("opShort", shortMap, 0);
    tick;
    checkOutput("opPass", pass, 0);

    // Wires 1 and 3 shorted
    mode = 2;
    applyStimulus(-1, -1, -1);
    checkOutput("shClrOpen", openAtStart, 0);
    checkOutput("shOpen", openMap, 0);
    checkOutput("shShort", shortMap, 4'b1010);
    tick;
    checkOutput("shPass", pass, 0);
    checkOutput("shMapsKept", shortMap, 4'b1010);

    // Start while busy, spurious ready in DRIVE, start during DONE
    mode = 0;
    applyStimulus(5, 20, 10);
    checkOutput("bsClrShort", shortAtStart, 0);
    checkOutput("bsCycles", cycToDone, 40);
    checkOutput("bsShort", shortMap, 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    checkOutput("bsDoneStart", busy, 0);
    checkOutput("bsDonePulse", done, 0);
    checkOutput("bsPass", pass, 1);
    tick;
    checkOutput("bsIdle", busy, 0);

    // Reset during SETTLE of wire 1
    mode = 3;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (10) tick;
    checkOutput("rmOpenW0", openMap, 4'b0001);
    repeat (4) tick;
    checkOutput("rmSettleEn", enTimer, 1);
    checkOutput("rmSettleDrv", drv, 4'b0010);
    resetn = 1'b0;
    #1;
    checkOutput("rmBusy", busy, 0);
    checkOutput("rmDone", done, 0);
    checkOutput("rmDrv", drv, 0);
    checkOutput("rmEn", enTimer, 0);
    checkOutput("rmOpen", openMap, 0);
    checkOutput("rmShort", shortMap, 0);
    checkOutput("rmPass", pass, 0);
    tick;
    resetn = 1'b1;
    tick;
    mode = 0;
    applyStimulus(-1, -1, -1);
    checkOutput("rrCycles", cycToDone, 40);
    checkOutput("rrOpen", openMap, 0);
    tick;
    checkOutput("rrPass", pass, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
